// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for a bank of common-select
// 7-segment digits. A shadow register holds the displayed value. A prescaler
// paces the digit pointer, and seg/an are registered one cycle behind it.
// Binary mode shows one bit per digit and hex mode shows one nibble per digit.
// Optional blanking suppresses leading zero digits.
module seg7_scan_driver #(
  parameter int DIGITS      = 4,
  parameter int WIDTH       = 16,
  parameter int REFRESH_DIV = 50000,
  localparam int IDXW       = (DIGITS > 1) ? $clog2(DIGITS) : 1,
  localparam int PW         = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [WIDTH-1:0]  value,
  input  logic              load,
  input  logic              mode,
  input  logic              blank_en,
  output logic [6:0]        seg,
  output logic [DIGITS-1:0] an,
  output logic [IDXW-1:0]   digit_idx
);

  // Segment pattern for a 4-bit digit value, active-high, bit 6 = a ... bit 0 = g.
  function automatic logic [6:0] glyph(input logic [3:0] d);
    logic [6:0] g;
    case (d)
      4'h0:    g = 7'b1111110;
      4'h1:    g = 7'b0110000;
      4'h2:    g = 7'b1101101;
      4'h3:    g = 7'b1111001;
      4'h4:    g = 7'b0110011;
      4'h5:    g = 7'b1011011;
      4'h6:    g = 7'b1011111;
      4'h7:    g = 7'b1110000;
      4'h8:    g = 7'b1111111;
      4'h9:    g = 7'b1111011;
      4'hA:    g = 7'b1110111;
      4'hB:    g = 7'b0011111;
      4'hC:    g = 7'b1001110;
      4'hD:    g = 7'b0111101;
      4'hE:    g = 7'b1001111;
      4'hF:    g = 7'b1000111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  logic [WIDTH-1:0]  shadow_r;
  logic [PW-1:0]     presc_r;
  logic              presc_last_s;
  logic              idx_last_s;
  logic [31:0]       shadow_ext_s;
  logic [7:0]        shamt_s;
  logic [31:0]       shifted_s;
  logic              in_range_s;
  logic              blank_s;
  logic [3:0]        digit_val_s;
  logic [6:0]        seg_next_s;
  logic [DIGITS-1:0] one_s;
  logic [DIGITS-1:0] an_next_s;

  // Terminal-count detection for the dwell counter and the digit pointer.
  always_comb begin
    presc_last_s = (presc_r == PW'(REFRESH_DIV - 1));
    idx_last_s   = (digit_idx == IDXW'(DIGITS - 1));
  end

  // Shadow capture of the displayed value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r <= {WIDTH{1'b0}};
    end else if (load) begin
      shadow_r <= value;
    end
  end

  // Dwell prescaler and digit pointer, which advances once per REFRESH_DIV cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_r   <= {PW{1'b0}};
      digit_idx <= {IDXW{1'b0}};
    end else if (presc_last_s) begin
      presc_r   <= {PW{1'b0}};
      digit_idx <= idx_last_s ? {IDXW{1'b0}} : digit_idx + IDXW'(1);
    end else begin
      presc_r   <= presc_r + PW'(1);
    end
  end

  // Select the current digit's source bits, then decide range, blanking and glyph.
  // shifted_s holds this digit and everything above it, so a zero shifted_s
  // means this digit and every higher in-range digit are zero.
  always_comb begin
    shadow_ext_s                = 32'd0;
    shadow_ext_s[WIDTH-1:0]     = shadow_r;
    shamt_s                     = mode ? (8'(digit_idx) << 2) : 8'(digit_idx);
    shifted_s                   = shadow_ext_s >> shamt_s;
    in_range_s                  = (shamt_s < 8'(WIDTH));
    digit_val_s                 = mode ? shifted_s[3:0] : {3'b000, shifted_s[0]};
    blank_s                     = blank_en && (digit_idx != {IDXW{1'b0}}) && (shifted_s == 32'd0);
    if (!in_range_s) begin
      seg_next_s = 7'b0000000;
    end else if (blank_s) begin
      seg_next_s = 7'b0000000;
    end else begin
      seg_next_s = glyph(digit_val_s);
    end
    one_s      = {DIGITS{1'b0}};
    one_s[0]   = 1'b1;
    an_next_s  = one_s << digit_idx;
  end

  // Registered display outputs, one cycle behind digit_idx.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seg <= 7'b0000000;
      an  <= {DIGITS{1'b0}};
    end else begin
      seg <= seg_next_s;
      an  <= an_next_s;
    end
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Time-multiplexed driver for a bank of DIGITS common-select 7-segment digits, showing an unsigned WIDTH-bit value.
- Two modes: binary (one bit per digit, glyph "0"/"1") and hex (one nibble per digit, glyphs 0-F); optional leading-zero blanking.
- Sits between datapath result registers and the board display pins.
- With DIGITS=1, WIDTH=1, binary mode it is the single-bit 0/1 display, now registered and scanned.

Parameters:
- DIGITS, 4, number of physical digits scanned (1..8).
- WIDTH, 16, width of the displayed value (1..32).
- REFRESH_DIV, 50000, clock cycles each digit stays selected (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- value  input  WIDTH  unsigned value to display.
- load  input  1  when 1, value is captured into the shadow register at this edge.
- mode  input  1  0 = binary (digit i shows bit i), 1 = hex (digit i shows nibble value[4i+3:4i]).
- blank_en  input  1  1 = blank leading zero digits.
- seg  output  7  segment drive, active-high, seg[6]=a ... seg[0]=g.
- an  output  DIGITS  one-hot active-high digit select.
- digit_idx  output  clog2(DIGITS) (min 1)  index of the currently selected digit.

Behaviour:
- Reset (rst_n=0 at a clock edge): shadow=0, prescaler=0, digit_idx=0, seg=7'b0000000, an=0. Reset mid-scan aborts immediately with no partial state.
- Shadow: load=1 captures value at the edge. The display reads only the shadow, never value directly.
- Prescaler: counts 0..REFRESH_DIV-1. At terminal count it wraps to 0 and digit_idx advances. digit_idx wraps DIGITS-1 -> 0.
- REFRESH_DIV=1: digit_idx advances every cycle.
- seg and an are registered from the current digit_idx, shadow, mode and blank_en, so they lag digit_idx by 1 cycle.
- First cycle after reset release: an=one-hot(0), seg=glyph of digit 0.
- Digit source:
  - Binary: bit i of the shadow if i<WIDTH, else out-of-range.
  - Hex: nibble i, zero-padded above WIDTH, if 4i<WIDTH, else out-of-range.
  - Out-of-range digits: seg=0, an still asserted (scan timing stays uniform).
- Glyphs:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000.
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111.
- Blanking: with blank_en=1, digit i>0 shows seg=0 when digit i and all in-range digits above it are zero. Digit 0 is never blanked, so the value 0 displays "0".
- Changes to mode or blank_en take effect on the next seg/an register update; no scan restart.
- load coinciding with a digit advance: the new digit is rendered from the newly loaded shadow.
- Both an and seg are 0 only while in reset; after reset exactly one an bit is always high.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with load=1, value=16'hFFFF -> seg=0, an=0, digit_idx=0; first cycle after release, an=0001 and seg=1111110 (shadow=0).
- Hex scan (REFRESH_DIV=2): load 16'h3A0F, mode=1, blank_en=0 -> an steps 0001,0010,0100,1000 every 2 cycles, then wraps to 0001; seg=1000111, 1111110, 1110111, 1111001 respectively.
- Binary mode (DIGITS=4, WIDTH=2): load 2'b10 -> digit0 seg=1111110, digit1 seg=0110000, digits 2-3 seg=0000000 with an still asserted.
- Blanking (mode=1, blank_en=1):
  - Load 16'h00A0 -> digits 3,2 seg=0; digit1=1110111, digit0=1111110.
  - Load 0 -> only digit0 lit, showing 1111110.
- Load/advance collision: assert load with 16'h1111 on the exact cycle of a digit advance -> the next rendered digit shows 0110000, not the old shadow.
- Reset mid-scan: drop rst_n while digit_idx=2 -> next cycle digit_idx=0, an=0, seg=0, and the scan restarts from digit 0 after release.
